// File: rtl/render_scheduler.sv
// render_scheduler: sequences the per-frame render passes (first-person, then optional minimap)
// and time-multiplexes the shared grid-memory and VGA ports between the two renderer clients.
// Ports: clock/reset (sync, active-high); frame_tick/enable request a frame; player_*_in are
//   snapshotted to player_* once per frame; fpv_*/map_* are the client start/done/pixel/grid
//   ports; grid_*/vga_* are the shared ports; busy, frame_count, overrun_count report status.
// Shared-port muxes are combinational (zero latency). Ticks that arrive while a frame is in
// flight are dropped and counted, never queued.
module render_scheduler #(
  parameter int MAP_ENABLE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic [13:0] player_pos_x_in,
  input  logic [12:0] player_pos_y_in,
  input  logic [7:0]  player_angle_in,
  output logic [13:0] player_pos_x,
  output logic [12:0] player_pos_y,
  output logic [7:0]  player_angle,
  output logic        fpv_start,
  input  logic        fpv_done,
  input  logic [5:0]  fpv_grid_x,
  input  logic [4:0]  fpv_grid_y,
  input  logic [7:0]  fpv_vga_x,
  input  logic [6:0]  fpv_vga_y,
  input  logic [17:0] fpv_colour,
  input  logic        fpv_write,
  output logic        map_start,
  input  logic        map_done,
  input  logic [5:0]  map_grid_x,
  input  logic [4:0]  map_grid_y,
  input  logic [7:0]  map_vga_x,
  input  logic [6:0]  map_vga_y,
  input  logic [17:0] map_colour,
  input  logic        map_write,
  output logic [5:0]  grid_x,
  output logic [4:0]  grid_y,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [17:0] vga_colour,
  output logic        vga_write,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [7:0]  overrun_count
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LATCH      = 3'd1,
    START_FPV  = 3'd2,
    WAIT_FPV   = 3'd3,
    START_MAP  = 3'd4,
    WAIT_MAP   = 3'd5,
    FRAME_DONE = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] pos_x_q, pos_x_d;
  logic [12:0] pos_y_q, pos_y_d;
  logic [7:0]  angle_q, angle_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [7:0]  overrun_q, overrun_d;

  // Next-state, snapshot and counter logic.
  always_comb begin
    state_d       = state_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    angle_d       = angle_q;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;

    case (state_q)
      IDLE: begin
        if (frame_tick && enable) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        pos_x_d = player_pos_x_in;
        pos_y_d = player_pos_y_in;
        angle_d = player_angle_in;
        state_d = START_FPV;
      end
      START_FPV: state_d = WAIT_FPV;
      WAIT_FPV: begin
        if (fpv_done) begin
          state_d = (MAP_ENABLE != 0) ? START_MAP : FRAME_DONE;
        end
      end
      START_MAP: state_d = WAIT_MAP;
      WAIT_MAP: begin
        if (map_done) begin
          state_d = FRAME_DONE;
        end
      end
      FRAME_DONE: begin
        frame_count_d = frame_count_q + 16'd1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Any tick seen outside IDLE (including the FRAME_DONE cycle) is a dropped frame.
    if (frame_tick && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      angle_q       <= '0;
      frame_count_q <= '0;
      overrun_q     <= '0;
    end else begin
      state_q       <= state_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      angle_q       <= angle_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
    end
  end

  // Port ownership follows the pass in progress; no owner means no pixel writes.
  logic fpv_owns, map_owns;
  assign fpv_owns = (state_q == START_FPV) || (state_q == WAIT_FPV);
  assign map_owns = (state_q == START_MAP) || (state_q == WAIT_MAP);

  always_comb begin
    grid_x     = fpv_grid_x;
    grid_y     = fpv_grid_y;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_write  = 1'b0;
    if (fpv_owns) begin
      vga_x      = fpv_vga_x;
      vga_y      = fpv_vga_y;
      vga_colour = fpv_colour;
      vga_write  = fpv_write & ~reset;
    end else if (map_owns) begin
      grid_x     = map_grid_x;
      grid_y     = map_grid_y;
      vga_x      = map_vga_x;
      vga_y      = map_vga_y;
      vga_colour = map_colour;
      vga_write  = map_write & ~reset;
    end
  end

  // Strobes are qualified with reset so a reset cycle never leaks a start or busy.
  assign fpv_start     = (state_q == START_FPV) & ~reset;
  assign map_start     = (state_q == START_MAP) & ~reset;
  assign busy          = (state_q != IDLE) & ~reset;
  assign player_pos_x  = pos_x_q;
  assign player_pos_y  = pos_y_q;
  assign player_angle  = angle_q;
  assign frame_count   = frame_count_q;
  assign overrun_count = overrun_q;

endmodule

// File: tb/tb_render_scheduler.sv
module tb_render_scheduler;

  logic        clock = 1'b0;
  logic        reset, frame_tick, enable;
  logic [13:0] px_in;
  logic [12:0] py_in;
  logic [7:0]  ang_in;
  logic        fpv_done, fpv_write, map_done, map_write;
  logic [5:0]  fpv_grid_x, map_grid_x;
  logic [4:0]  fpv_grid_y, map_grid_y;
  logic [7:0]  fpv_vga_x, map_vga_x;
  logic [6:0]  fpv_vga_y, map_vga_y;
  logic [17:0] fpv_colour, map_colour;

  // Outputs of the MAP_ENABLE=1 instance
  logic [13:0] player_pos_x;
  logic [12:0] player_pos_y;
  logic [7:0]  player_angle;
  logic        fpv_start, map_start, vga_write, busy;
  logic [5:0]  grid_x;
  logic [4:0]  grid_y;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [17:0] vga_colour;
  logic [15:0] frame_count;
  logic [7:0]  overrun_count;

  // Outputs of the MAP_ENABLE=0 instance (same stimulus)
  logic [13:0] player_pos_x_b;
  logic [12:0] player_pos_y_b;
  logic [7:0]  player_angle_b;
  logic        fpv_start_b, map_start_b, vga_write_b, busy_b;
  logic [5:0]  grid_x_b;
  logic [4:0]  grid_y_b;
  logic [7:0]  vga_x_b;
  logic [6:0]  vga_y_b;
  logic [17:0] vga_colour_b;
  logic [15:0] frame_count_b;
  logic [7:0]  overrun_count_b;

  int n_chk = 0;
  int n_err = 0;
  int exp_fc = 0;
  int exp_ovr = 0;
  int map_b_seen = 0;

  always #5 clock = ~clock;

  always @(posedge clock) if (map_start_b) map_b_seen = map_b_seen + 1;

  render_scheduler #(.MAP_ENABLE(1)) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .enable(enable),
    .player_pos_x_in(px_in), .player_pos_y_in(py_in), .player_angle_in(ang_in),
    .player_pos_x(player_pos_x), .player_pos_y(player_pos_y), .player_angle(player_angle),
    .fpv_start(fpv_start), .fpv_done(fpv_done), .fpv_grid_x(fpv_grid_x), .fpv_grid_y(fpv_grid_y),
    .fpv_vga_x(fpv_vga_x), .fpv_vga_y(fpv_vga_y), .fpv_colour(fpv_colour), .fpv_write(fpv_write),
    .map_start(map_start), .map_done(map_done), .map_grid_x(map_grid_x), .map_grid_y(map_grid_y),
    .map_vga_x(map_vga_x), .map_vga_y(map_vga_y), .map_colour(map_colour), .map_write(map_write),
    .grid_x(grid_x), .grid_y(grid_y), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_write(vga_write), .busy(busy), .frame_count(frame_count), .overrun_count(overrun_count)
  );

  render_scheduler #(.MAP_ENABLE(0)) dut_nomap (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .enable(enable),
    .player_pos_x_in(px_in), .player_pos_y_in(py_in), .player_angle_in(ang_in),
    .player_pos_x(player_pos_x_b), .player_pos_y(player_pos_y_b), .player_angle(player_angle_b),
    .fpv_start(fpv_start_b), .fpv_done(fpv_done), .fpv_grid_x(fpv_grid_x), .fpv_grid_y(fpv_grid_y),
    .fpv_vga_x(fpv_vga_x), .fpv_vga_y(fpv_vga_y), .fpv_colour(fpv_colour), .fpv_write(fpv_write),
    .map_start(map_start_b), .map_done(map_done), .map_grid_x(map_grid_x), .map_grid_y(map_grid_y),
    .map_vga_x(map_vga_x), .map_vga_y(map_vga_y), .map_colour(map_colour), .map_write(map_write),
    .grid_x(grid_x_b), .grid_y(grid_y_b), .vga_x(vga_x_b), .vga_y(vga_y_b), .vga_colour(vga_colour_b),
    .vga_write(vga_write_b), .busy(busy_b), .frame_count(frame_count_b), .overrun_count(overrun_count_b)
  );

  // Advance to just after the next rising edge; inputs set afterwards are sampled at the next edge.
  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next();
    next();
    reset = 1'b0;
    exp_fc = 0;
    exp_ovr = 0;
  endtask

  // Issue a tick with the given player state held through the latch cycle; returns in START_FPV.
  task automatic launch(input logic [13:0] x, input logic [12:0] y, input logic [7:0] a);
    next();
    px_in = x; py_in = y; ang_in = a;
    frame_tick = 1'b1;
    next();
    frame_tick = 1'b0;
    next();
  endtask

  task automatic pulse_fpv_done();
    fpv_done = 1'b1;
    next();
    fpv_done = 1'b0;
  endtask

  task automatic pulse_map_done();
    map_done = 1'b1;
    next();
    map_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    frame_tick = 1'b1;
    enable = 1'b1;
    next();
    next();
    reset = 1'b0;
    frame_tick = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_chk++; if (frame_count !== 16'd0 || overrun_count !== 8'd0) begin n_err++;
      $display("FAIL reset_counters: got fc=%0d ovr=%0d want 0/0", frame_count, overrun_count); end
    n_chk++; if ({player_pos_x, player_pos_y, player_angle} !== 35'd0) begin n_err++;
      $display("FAIL reset_snapshot: got %h/%h/%h want 0", player_pos_x, player_pos_y, player_angle); end
    n_chk++; if (fpv_start !== 1'b0 || map_start !== 1'b0 || vga_write !== 1'b0) begin n_err++;
      $display("FAIL reset_strobes: got fs=%0b ms=%0b vw=%0b want 0", fpv_start, map_start, vga_write); end
    next();
    next();
    #1;
    n_chk++; if (busy !== 1'b0 || fpv_start !== 1'b0) begin n_err++;
      $display("FAIL reset_tick_ignored: got busy=%0b fs=%0b want 0/0", busy, fpv_start); end
  endtask

  task automatic test_normal_frames();
    logic [13:0] x; logic [12:0] y; logic [7:0] a;
    int d, md, extra, hold;
    for (int f = 0; f < 5; f++) begin
      if (f == 0) begin
        x = 14'h1234; y = 13'h0ABC; a = 8'h40; d = 10; md = 3;
      end else begin
        x = 14'($urandom); y = 13'($urandom); a = 8'($urandom);
        d = $urandom_range(1, 12); md = $urandom_range(0, 8);
      end
      launch(x, y, a);
      #1;
      n_chk++; if (fpv_start !== 1'b1 || busy !== 1'b1) begin n_err++;
        $display("FAIL frame%0d_fpv_start: got fs=%0b busy=%0b want 1/1", f, fpv_start, busy); end
      n_chk++; if (player_pos_x !== x || player_pos_y !== y || player_angle !== a) begin n_err++;
        $display("FAIL frame%0d_snapshot: got %h/%h/%h want %h/%h/%h", f,
                 player_pos_x, player_pos_y, player_angle, x, y, a); end
      px_in = 14'($urandom); py_in = 13'($urandom); ang_in = 8'($urandom);
      next();
      extra = 0; hold = 0;
      for (int i = 0; i < d; i++) begin
        if (fpv_start || map_start) extra++;
        if (player_pos_x !== x || player_pos_y !== y || player_angle !== a) hold++;
        px_in = 14'($urandom);
        next();
      end
      pulse_fpv_done();
      #1;
      n_chk++; if (map_start !== 1'b1 || extra != 0 || hold != 0) begin n_err++;
        $display("FAIL frame%0d_map_start: got ms=%0b extra=%0d hold=%0d want 1/0/0", f, map_start, extra, hold); end
      next();
      for (int i = 0; i < md; i++) begin
        if (fpv_start || map_start) extra++;
        next();
      end
      pulse_map_done();
      #1;
      n_chk++; if (busy !== 1'b1 || frame_count !== 16'(exp_fc) || extra != 0) begin n_err++;
        $display("FAIL frame%0d_done_state: got busy=%0b fc=%0d extra=%0d want 1/%0d/0", f, busy, frame_count, extra, exp_fc); end
      exp_fc++;
      next();
      #1;
      n_chk++; if (busy !== 1'b0 || frame_count !== 16'(exp_fc)) begin n_err++;
        $display("FAIL frame%0d_complete: got busy=%0b fc=%0d want 0/%0d", f, busy, frame_count, exp_fc); end
      n_chk++; if (player_pos_x !== x || player_pos_y !== y || player_angle !== a) begin n_err++;
        $display("FAIL frame%0d_hold: got %h/%h/%h want %h/%h/%h", f,
                 player_pos_x, player_pos_y, player_angle, x, y, a); end
    end
  endtask

  task automatic test_mux();
    launch(14'($urandom), 13'($urandom), 8'($urandom));
    next();
    fpv_write = 1'b1; map_write = 1'b1; fpv_vga_x = 8'd5; map_vga_x = 8'd9;
    fpv_vga_y = 7'($urandom); map_vga_y = 7'($urandom);
    fpv_colour = 18'($urandom); map_colour = 18'($urandom);
    fpv_grid_x = 6'($urandom); fpv_grid_y = 5'($urandom);
    map_grid_x = 6'($urandom); map_grid_y = 5'($urandom);
    #1;
    n_chk++; if (vga_x !== 8'd5 || vga_write !== 1'b1 || vga_y !== fpv_vga_y || vga_colour !== fpv_colour) begin n_err++;
      $display("FAIL mux_fpv_pixel: got x=%0d w=%0b y=%0d c=%h want 5/1/%0d/%h", vga_x, vga_write, vga_y, vga_colour, fpv_vga_y, fpv_colour); end
    n_chk++; if (grid_x !== fpv_grid_x || grid_y !== fpv_grid_y) begin n_err++;
      $display("FAIL mux_fpv_grid: got %0d/%0d want %0d/%0d", grid_x, grid_y, fpv_grid_x, fpv_grid_y); end
    fpv_write = 1'b0;
    #1;
    n_chk++; if (vga_write !== 1'b0) begin n_err++; $display("FAIL mux_nonowner_map: got w=%0b want 0", vga_write); end
    fpv_write = 1'b1;
    pulse_fpv_done();
    next();
    #1;
    n_chk++; if (vga_x !== 8'd9 || vga_write !== 1'b1 || vga_y !== map_vga_y || vga_colour !== map_colour) begin n_err++;
      $display("FAIL mux_map_pixel: got x=%0d w=%0b y=%0d c=%h want 9/1/%0d/%h", vga_x, vga_write, vga_y, vga_colour, map_vga_y, map_colour); end
    n_chk++; if (grid_x !== map_grid_x || grid_y !== map_grid_y) begin n_err++;
      $display("FAIL mux_map_grid: got %0d/%0d want %0d/%0d", grid_x, grid_y, map_grid_x, map_grid_y); end
    map_write = 1'b0;
    #1;
    n_chk++; if (vga_write !== 1'b0) begin n_err++; $display("FAIL mux_nonowner_fpv: got w=%0b want 0", vga_write); end
    map_write = 1'b1;
    pulse_map_done();
    next();
    exp_fc++;
    #1;
    n_chk++; if (vga_write !== 1'b0 || vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 18'd0) begin n_err++;
      $display("FAIL mux_idle: got w=%0b x=%0d y=%0d c=%h want 0", vga_write, vga_x, vga_y, vga_colour); end
    n_chk++; if (grid_x !== fpv_grid_x || grid_y !== fpv_grid_y) begin n_err++;
      $display("FAIL mux_idle_grid: got %0d/%0d want %0d/%0d", grid_x, grid_y, fpv_grid_x, fpv_grid_y); end
    fpv_write = 1'b0; map_write = 1'b0;
  endtask

  task automatic test_done_edge_tick();
    launch(14'($urandom), 13'($urandom), 8'($urandom));
    next();
    pulse_fpv_done();
    next();
    pulse_map_done();
    frame_tick = 1'b1;
    next();
    frame_tick = 1'b0;
    exp_fc++;
    exp_ovr++;
    #1;
    n_chk++; if (overrun_count !== 8'(exp_ovr) || busy !== 1'b0 || frame_count !== 16'(exp_fc)) begin n_err++;
      $display("FAIL done_edge_tick: got ovr=%0d busy=%0b fc=%0d want %0d/0/%0d", overrun_count, busy, frame_count, exp_ovr, exp_fc); end
    next();
    next();
    #1;
    n_chk++; if (busy !== 1'b0 || fpv_start !== 1'b0) begin n_err++;
      $display("FAIL done_edge_dropped: got busy=%0b fs=%0b want 0/0", busy, fpv_start); end
  endtask

  task automatic test_overrun();
    int starts, idles;
    launch(14'($urandom), 13'($urandom), 8'($urandom));
    next();
    starts = 0; idles = 0;
    frame_tick = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      map_done = 1'($urandom);
      next();
      if (fpv_start || map_start) starts++;
      if (!busy) idles++;
      if (i == 100) begin
        #1;
        n_chk++; if (overrun_count !== 8'(exp_ovr + 100)) begin n_err++;
          $display("FAIL overrun_partial: got %0d want %0d", overrun_count, exp_ovr + 100); end
      end
    end
    frame_tick = 1'b0;
    map_done = 1'b0;
    exp_ovr = (exp_ovr + 300 > 255) ? 255 : exp_ovr + 300;
    #1;
    n_chk++; if (overrun_count !== 8'(exp_ovr)) begin n_err++;
      $display("FAIL overrun_saturate: got %0d want %0d", overrun_count, exp_ovr); end
    n_chk++; if (starts != 0 || idles != 0) begin n_err++;
      $display("FAIL overrun_no_restart: got starts=%0d idles=%0d want 0/0", starts, idles); end
    pulse_fpv_done();
    #1;
    n_chk++; if (map_start !== 1'b1) begin n_err++;
      $display("FAIL stray_map_done: got ms=%0b want 1 (still waiting on fpv)", map_start); end
    next();
    pulse_map_done();
    next();
    exp_fc++;
    #1;
    n_chk++; if (frame_count !== 16'(exp_fc) || overrun_count !== 8'(exp_ovr)) begin n_err++;
      $display("FAIL overrun_frame_end: got fc=%0d ovr=%0d want %0d/%0d", frame_count, overrun_count, exp_fc, exp_ovr); end
  endtask

  task automatic test_no_map();
    logic [13:0] x; logic [12:0] y; logic [7:0] a;
    int seen0;
    do_reset();
    seen0 = map_b_seen;
    x = 14'($urandom); y = 13'($urandom); a = 8'($urandom);
    fpv_grid_x = 6'($urandom); fpv_grid_y = 5'($urandom);
    launch(x, y, a);
    #1;
    n_chk++; if (fpv_start_b !== 1'b1) begin n_err++; $display("FAIL nomap_fpv_start: got %0b want 1", fpv_start_b); end
    next();
    repeat ($urandom_range(1, 6)) next();
    pulse_fpv_done();
    #1;
    n_chk++; if (busy_b !== 1'b1 || frame_count_b !== 16'd0 || map_start_b !== 1'b0) begin n_err++;
      $display("FAIL nomap_frame_done: got busy=%0b fc=%0d ms=%0b want 1/0/0", busy_b, frame_count_b, map_start_b); end
    n_chk++; if (vga_write_b !== 1'b0 || vga_x_b !== 8'd0 || vga_y_b !== 7'd0 || vga_colour_b !== 18'd0
                 || grid_x_b !== fpv_grid_x || grid_y_b !== fpv_grid_y) begin n_err++;
      $display("FAIL nomap_ports_unowned: got w=%0b x=%0d y=%0d c=%h g=%0d/%0d", vga_write_b, vga_x_b, vga_y_b, vga_colour_b, grid_x_b, grid_y_b); end
    next();
    #1;
    n_chk++; if (busy_b !== 1'b0 || frame_count_b !== 16'd1 || overrun_count_b !== 8'd0) begin n_err++;
      $display("FAIL nomap_complete: got busy=%0b fc=%0d ovr=%0d want 0/1/0", busy_b, frame_count_b, overrun_count_b); end
    n_chk++; if (player_pos_x_b !== x || player_pos_y_b !== y || player_angle_b !== a) begin n_err++;
      $display("FAIL nomap_snapshot: got %h/%h/%h want %h/%h/%h", player_pos_x_b, player_pos_y_b, player_angle_b, x, y, a); end
    repeat (4) next();
    n_chk++; if (map_b_seen != seen0) begin n_err++;
      $display("FAIL nomap_no_map_start: got %0d pulses want 0", map_b_seen - seen0); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic [13:0] x; logic [12:0] y; logic [7:0] a;
    int starts;
    launch(14'($urandom), 13'($urandom), 8'($urandom));
    next();
    pulse_fpv_done();
    next();
    frame_tick = 1'b1;
    frame_tick = 1'b1; reset = 1'b1;
    next();
    reset = 1'b0; frame_tick = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0 || frame_count !== 16'd0 || overrun_count !== 8'd0) begin n_err++;
      $display("FAIL midreset_state: got busy=%0b fc=%0d ovr=%0d want 0/0/0", busy, frame_count, overrun_count); end
    n_chk++; if ({player_pos_x, player_pos_y, player_angle} !== 35'd0) begin n_err++;
      $display("FAIL midreset_snapshot: got %h/%h/%h want 0", player_pos_x, player_pos_y, player_angle); end
    starts = 0;
    map_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next();
      if (fpv_start || map_start || busy) starts++;
    end
    map_done = 1'b0;
    enable = 1'b0;
    frame_tick = 1'b1;
    next();
    frame_tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next();
      if (fpv_start || map_start || busy) starts++;
    end
    #1;
    n_chk++; if (starts != 0 || overrun_count !== 8'd0 || frame_count !== 16'd0) begin n_err++;
      $display("FAIL midreset_quiet: got activity=%0d ovr=%0d fc=%0d want 0/0/0", starts, overrun_count, frame_count); end
    enable = 1'b1;
    x = 14'($urandom); y = 13'($urandom); a = 8'($urandom);
    launch(x, y, a);
    #1;
    n_chk++; if (fpv_start !== 1'b1 || player_pos_x !== x || player_pos_y !== y || player_angle !== a) begin n_err++;
      $display("FAIL midreset_clean_frame: got fs=%0b snap=%h/%h/%h want 1 %h/%h/%h", fpv_start, player_pos_x, player_pos_y, player_angle, x, y, a); end
    next();
    pulse_fpv_done();
    next();
    pulse_map_done();
    next();
    #1;
    n_chk++; if (frame_count !== 16'd1 || busy !== 1'b0) begin n_err++;
      $display("FAIL midreset_frame_count: got fc=%0d busy=%0b want 1/0", frame_count, busy); end
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; enable = 1'b1;
    px_in = '0; py_in = '0; ang_in = '0;
    fpv_done = 1'b0; fpv_write = 1'b0; map_done = 1'b0; map_write = 1'b0;
    fpv_grid_x = '0; fpv_grid_y = '0; map_grid_x = '0; map_grid_y = '0;
    fpv_vga_x = '0; fpv_vga_y = '0; fpv_colour = '0;
    map_vga_x = '0; map_vga_y = '0; map_colour = '0;
    test_reset();
    test_normal_frames();
    test_mux();
    test_done_edge_tick();
    test_overrun();
    test_no_map();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/render_scheduler.md
RENDER_SCHEDULER -- requirements
Module: render_scheduler

Interface
REQ-001 Parameter MAP_ENABLE, default 1, meaning: 1 = run minimap pass after first-person pass each frame; 0 = skip minimap pass.
REQ-002 clock  input  1  system clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 frame_tick  input  1  one-cycle pulse requesting a new frame render.
REQ-005 enable  input  1  1 = accept frame_tick; 0 = ignore frame_tick in IDLE.
REQ-006 player_pos_x_in / player_pos_y_in / player_angle_in  input  14/13/8  live player state.
REQ-007 player_pos_x / player_pos_y / player_angle  output  14/13/8  per-frame snapshot of player state, fed to both clients.
REQ-008 fpv_start  output  1  start pulse to the first-person renderer.
REQ-009 fpv_done  input  1  completion pulse from the first-person renderer.
REQ-010 fpv_grid_x / fpv_grid_y  input  6/5  grid address from the first-person renderer.
REQ-011 fpv_vga_x / fpv_vga_y / fpv_colour / fpv_write  input  8/7/18/1  pixel port from the first-person renderer.
REQ-012 map_start, map_done, map_grid_x, map_grid_y, map_vga_x, map_vga_y, map_colour, map_write: same widths and meanings as the fpv_* signals, for the minimap renderer.
REQ-013 grid_x / grid_y  output  6/5  shared grid memory address; grid data returns directly to both clients.
REQ-014 vga_x / vga_y / vga_colour / vga_write  output  8/7/18/1  shared VGA adapter port.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 frame_count  output  16  completed-frame counter.
REQ-017 overrun_count  output  8  dropped-tick counter.

Function
REQ-018 FSM states: IDLE, LATCH, START_FPV, WAIT_FPV, START_MAP, WAIT_MAP, FRAME_DONE.
REQ-019 IDLE -> LATCH when frame_tick & enable; otherwise remain in IDLE.
REQ-020 LATCH: capture all three player_*_in values into the snapshot registers; next state START_FPV.
REQ-021 START_FPV: fpv_start = 1 for exactly this one cycle; next state WAIT_FPV.
REQ-022 WAIT_FPV: hold until fpv_done = 1; then go to START_MAP if MAP_ENABLE = 1, else to FRAME_DONE.
REQ-023 START_MAP: map_start = 1 for exactly this one cycle; next state WAIT_MAP.
REQ-024 WAIT_MAP: hold until map_done = 1; then go to FRAME_DONE.
REQ-025 FRAME_DONE: frame_count increments by 1 (wraps 65535 -> 0); next state IDLE.
REQ-026 The snapshot registers change only in LATCH; they stay constant from LATCH until the next LATCH.
REQ-027 Ownership: the fpv client owns both shared ports in START_FPV and WAIT_FPV; the map client owns them in START_MAP and WAIT_MAP.
REQ-028 Shared ports are combinational muxes of the owner's signals, zero cycles of latency.
REQ-029 With no owner (IDLE, LATCH, FRAME_DONE): vga_write = 0, vga_x/vga_y/vga_colour = 0, grid_x/grid_y = fpv_grid_x/fpv_grid_y.
REQ-030 A write from the non-owner never reaches vga_write.
REQ-031 fpv_done outside WAIT_FPV and map_done outside WAIT_MAP are ignored.
REQ-032 frame_tick in any state other than IDLE is dropped and increments overrun_count, which saturates at 255.
REQ-033 frame_tick is ignored in IDLE when enable = 0 (no overrun count).
REQ-034 A tick arriving in the same cycle as the FRAME_DONE -> IDLE transition is dropped (counted as overrun).
REQ-035 A done pulse in the same cycle as a start pulse is not possible; done is sampled only in the WAIT_* states.

Reset
REQ-036 Reset (any cycle) forces: state = IDLE; snapshot, frame_count, overrun_count = 0; fpv_start, map_start, vga_write, busy = 0.
REQ-037 Reset mid-frame abandons the frame with no further start pulses; frame_count does not increment.
REQ-038 A frame_tick in the reset cycle is ignored.

Verification
REQ-039 Normal frame: MAP_ENABLE=1, pos_x=0x1234, pos_y=0x0ABC, angle=0x40, tick -> fpv_start pulse 2 cycles after tick; fpv_done after 10 cycles -> map_start next cycle; map_done -> frame_count=1, busy=0, snapshot=0x1234/0x0ABC/0x40.
REQ-040 Snapshot hold: change player_*_in during WAIT_FPV -> player_* outputs unchanged until next LATCH.
REQ-041 Mux: fpv_write=1, map_write=1 in WAIT_FPV, fpv_vga_x=5, map_vga_x=9 -> vga_x=5, vga_write=1; same stimulus in WAIT_MAP -> vga_x=9; in IDLE -> vga_write=0.
REQ-042 Overrun: 300 ticks during WAIT_FPV -> overrun_count=255, no extra fpv_start; stray map_done in WAIT_FPV -> no state change.
REQ-043 MAP_ENABLE=0: tick, then fpv_done -> FRAME_DONE next cycle, map_start never asserted, frame_count=1.
REQ-044 Reset mid WAIT_MAP -> next cycle IDLE, all counters 0; subsequent tick with enable=1 starts a clean frame; frame_tick with enable=0 -> stays IDLE.
